// File: rtl/stg_wb.sv
// stg_wb: write-back stage. It registers the GP, SR and AR write ports and assembles
// two-beat SR loads (low half first, then high half) while stalling upstream.
`default_nettype none

module stg_wb #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 48,
  parameter int TGT_GP_W = 4,
  parameter int TGT_SR_W = 2,
  parameter int TGT_AR_W = 2,
  parameter int CNT_W    = 32,
  parameter int OPC_W    = 8
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_valid,
  input  logic                iw_flush,
  input  logic [ADDR_W-1:0]   iw_pc,
  input  logic [OPC_W-1:0]    iw_opc,
  input  logic [TGT_GP_W-1:0] iw_tgt_gp,
  input  logic                iw_tgt_gp_we,
  input  logic [TGT_SR_W-1:0] iw_tgt_sr,
  input  logic                iw_tgt_sr_we,
  input  logic [TGT_AR_W-1:0] iw_tgt_ar,
  input  logic                iw_tgt_ar_we,
  input  logic                iw_ld,
  input  logic                iw_srld,
  input  logic                iw_mem_mp,
  input  logic [DATA_W-1:0]   iw_mem_data0,
  input  logic [DATA_W-1:0]   iw_mem_data1,
  input  logic [DATA_W-1:0]   iw_result,
  input  logic [ADDR_W-1:0]   iw_ar_result,
  output logic                ow_gp_we,
  output logic [TGT_GP_W-1:0] ow_gp_idx,
  output logic [DATA_W-1:0]   ow_gp_data,
  output logic                ow_sr_we,
  output logic [TGT_SR_W-1:0] ow_sr_idx,
  output logic [ADDR_W-1:0]   ow_sr_data,
  output logic                ow_ar_we,
  output logic [TGT_AR_W-1:0] ow_ar_idx,
  output logic [ADDR_W-1:0]   ow_ar_data,
  output logic                ow_stall,
  output logic [ADDR_W-1:0]   ow_pc,
  output logic [OPC_W-1:0]    ow_opc,
  output logic [CNT_W-1:0]    ow_retire_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SR_HI = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] sel_data;
  logic              live;

  // Context of an SR load held between its two beats.
  logic [DATA_W-1:0]   sr_lo, sr_lo_nxt;
  logic [TGT_SR_W-1:0] sr_pidx, sr_pidx_nxt;
  logic [ADDR_W-1:0]   sr_ppc, sr_ppc_nxt;
  logic [OPC_W-1:0]    sr_popc, sr_popc_nxt;

  logic                stall;
  logic                gp_we_nxt, sr_we_nxt, ar_we_nxt;
  logic [TGT_GP_W-1:0] gp_idx_nxt;
  logic [DATA_W-1:0]   gp_data_nxt;
  logic [TGT_SR_W-1:0] sr_idx_nxt;
  logic [ADDR_W-1:0]   sr_data_nxt;
  logic [TGT_AR_W-1:0] ar_idx_nxt;
  logic [ADDR_W-1:0]   ar_data_nxt;
  logic [ADDR_W-1:0]   pc_nxt;
  logic [OPC_W-1:0]    opc_nxt;
  logic [CNT_W-1:0]    cnt_nxt;

  assign sel_data = iw_mem_mp ? iw_mem_data0 : iw_mem_data1;
  assign live     = iw_valid & ~iw_flush;
  assign ow_stall = stall & ~iw_rst;

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    gp_we_nxt   = 1'b0;
    sr_we_nxt   = 1'b0;
    ar_we_nxt   = 1'b0;
    gp_idx_nxt  = ow_gp_idx;
    gp_data_nxt = ow_gp_data;
    sr_idx_nxt  = ow_sr_idx;
    sr_data_nxt = ow_sr_data;
    ar_idx_nxt  = ow_ar_idx;
    ar_data_nxt = ow_ar_data;
    pc_nxt      = ow_pc;
    opc_nxt     = ow_opc;
    cnt_nxt     = ow_retire_cnt;
    sr_lo_nxt   = sr_lo;
    sr_pidx_nxt = sr_pidx;
    sr_ppc_nxt  = sr_ppc;
    sr_popc_nxt = sr_popc;

    case (state)
      IDLE: begin
        gp_we_nxt   = iw_tgt_gp_we & live;
        gp_idx_nxt  = iw_tgt_gp;
        gp_data_nxt = iw_ld ? sel_data : iw_result;
        ar_we_nxt   = iw_tgt_ar_we & live;
        ar_idx_nxt  = iw_tgt_ar;
        ar_data_nxt = iw_ar_result;
        if (live && iw_srld) begin
          // First beat: keep the low half and the trace info until the high half arrives.
          stall       = 1'b1;
          state_nxt   = SR_HI;
          sr_lo_nxt   = sel_data;
          sr_pidx_nxt = iw_tgt_sr;
          sr_ppc_nxt  = iw_pc;
          sr_popc_nxt = iw_opc;
        end else begin
          sr_we_nxt   = iw_tgt_sr_we & live;
          sr_idx_nxt  = iw_tgt_sr;
          sr_data_nxt = iw_ar_result;
          if (live) begin
            cnt_nxt = ow_retire_cnt + CNT_W'(1);
            pc_nxt  = iw_pc;
            opc_nxt = iw_opc;
          end
        end
      end

      SR_HI: begin
        state_nxt = IDLE;
        if (!iw_flush) begin
          stall       = 1'b1;
          sr_we_nxt   = 1'b1;
          sr_idx_nxt  = sr_pidx;
          sr_data_nxt = {sel_data, sr_lo};
          cnt_nxt     = ow_retire_cnt + CNT_W'(1);
          pc_nxt      = sr_ppc;
          opc_nxt     = sr_popc;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state         <= IDLE;
      ow_gp_we      <= 1'b0;
      ow_gp_idx     <= '0;
      ow_gp_data    <= '0;
      ow_sr_we      <= 1'b0;
      ow_sr_idx     <= '0;
      ow_sr_data    <= '0;
      ow_ar_we      <= 1'b0;
      ow_ar_idx     <= '0;
      ow_ar_data    <= '0;
      ow_pc         <= '0;
      ow_opc        <= '0;
      ow_retire_cnt <= '0;
      sr_lo         <= '0;
      sr_pidx       <= '0;
      sr_ppc        <= '0;
      sr_popc       <= '0;
    end else begin
      state         <= state_nxt;
      ow_gp_we      <= gp_we_nxt;
      ow_gp_idx     <= gp_idx_nxt;
      ow_gp_data    <= gp_data_nxt;
      ow_sr_we      <= sr_we_nxt;
      ow_sr_idx     <= sr_idx_nxt;
      ow_sr_data    <= sr_data_nxt;
      ow_ar_we      <= ar_we_nxt;
      ow_ar_idx     <= ar_idx_nxt;
      ow_ar_data    <= ar_data_nxt;
      ow_pc         <= pc_nxt;
      ow_opc        <= opc_nxt;
      ow_retire_cnt <= cnt_nxt;
      sr_lo         <= sr_lo_nxt;
      sr_pidx       <= sr_pidx_nxt;
      sr_ppc        <= sr_ppc_nxt;
      sr_popc       <= sr_popc_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stg_wb.sv
// tb_stg_wb: directed and randomized checks of stg_wb against a transaction-level model.
`default_nettype none

module tb_stg_wb;
  localparam int DW = 24;
  localparam int AW = 48;
  localparam int CW = 4;

  logic          iw_clk = 1'b0;
  logic          iw_rst = 1'b0;
  logic          iw_valid, iw_flush, iw_ld, iw_srld, iw_mem_mp;
  logic          iw_tgt_gp_we, iw_tgt_sr_we, iw_tgt_ar_we;
  logic [3:0]    iw_tgt_gp;
  logic [1:0]    iw_tgt_sr, iw_tgt_ar;
  logic [AW-1:0] iw_pc, iw_ar_result;
  logic [7:0]    iw_opc;
  logic [DW-1:0] iw_mem_data0, iw_mem_data1, iw_result;

  logic          ow_gp_we, ow_sr_we, ow_ar_we, ow_stall;
  logic [3:0]    ow_gp_idx;
  logic [1:0]    ow_sr_idx, ow_ar_idx;
  logic [DW-1:0] ow_gp_data;
  logic [AW-1:0] ow_sr_data, ow_ar_data, ow_pc;
  logic [7:0]    ow_opc;
  logic [CW-1:0] ow_retire_cnt;

  int tests = 0;
  int fails = 0;

  stg_wb #(.CNT_W(CW)) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_valid(iw_valid), .iw_flush(iw_flush),
    .iw_pc(iw_pc), .iw_opc(iw_opc),
    .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we),
    .iw_tgt_sr(iw_tgt_sr), .iw_tgt_sr_we(iw_tgt_sr_we),
    .iw_tgt_ar(iw_tgt_ar), .iw_tgt_ar_we(iw_tgt_ar_we),
    .iw_ld(iw_ld), .iw_srld(iw_srld), .iw_mem_mp(iw_mem_mp),
    .iw_mem_data0(iw_mem_data0), .iw_mem_data1(iw_mem_data1),
    .iw_result(iw_result), .iw_ar_result(iw_ar_result),
    .ow_gp_we(ow_gp_we), .ow_gp_idx(ow_gp_idx), .ow_gp_data(ow_gp_data),
    .ow_sr_we(ow_sr_we), .ow_sr_idx(ow_sr_idx), .ow_sr_data(ow_sr_data),
    .ow_ar_we(ow_ar_we), .ow_ar_idx(ow_ar_idx), .ow_ar_data(ow_ar_data),
    .ow_stall(ow_stall), .ow_pc(ow_pc), .ow_opc(ow_opc), .ow_retire_cnt(ow_retire_cnt)
  );

  always #5 iw_clk = ~iw_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Transaction model: what each write port must show after an edge, plus a pending SR load.
  logic          m_gp_we, m_sr_we, m_ar_we, m_pend;
  logic [3:0]    m_gp_idx;
  logic [1:0]    m_sr_idx, m_ar_idx, m_pidx;
  logic [DW-1:0] m_gp_data, m_lo;
  logic [AW-1:0] m_sr_data, m_ar_data, m_pc, m_ppc;
  logic [7:0]    m_opc, m_popc;
  int            m_retired;
  logic [DW-1:0] m_sel;
  logic          m_live;

  always @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      m_gp_we = 0; m_sr_we = 0; m_ar_we = 0; m_pend = 0;
      m_gp_idx = 0; m_sr_idx = 0; m_ar_idx = 0; m_pidx = 0;
      m_gp_data = 0; m_lo = 0; m_sr_data = 0; m_ar_data = 0;
      m_pc = 0; m_ppc = 0; m_opc = 0; m_popc = 0; m_retired = 0;
    end else begin
      m_sel  = iw_mem_mp ? iw_mem_data0 : iw_mem_data1;
      m_live = iw_valid && !iw_flush;
      if (m_pend) begin
        m_pend  = 0;
        m_gp_we = 0;
        m_ar_we = 0;
        m_sr_we = !iw_flush;
        if (!iw_flush) begin
          m_sr_idx  = m_pidx;
          m_sr_data = {m_sel, m_lo};
          m_retired = m_retired + 1;
          m_pc      = m_ppc;
          m_opc     = m_popc;
        end
      end else begin
        m_gp_we   = iw_tgt_gp_we && m_live;
        m_gp_idx  = iw_tgt_gp;
        m_gp_data = iw_ld ? m_sel : iw_result;
        m_ar_we   = iw_tgt_ar_we && m_live;
        m_ar_idx  = iw_tgt_ar;
        m_ar_data = iw_ar_result;
        if (m_live && iw_srld) begin
          m_pend = 1; m_sr_we = 0;
          m_lo = m_sel; m_pidx = iw_tgt_sr; m_ppc = iw_pc; m_popc = iw_opc;
        end else begin
          m_sr_we   = iw_tgt_sr_we && m_live;
          m_sr_idx  = iw_tgt_sr;
          m_sr_data = iw_ar_result;
          if (m_live) begin
            m_retired = m_retired + 1;
            m_pc      = iw_pc;
            m_opc     = iw_opc;
          end
        end
      end
    end
  end

  always @(negedge iw_clk) begin
    if (!iw_rst) begin
      check("gp_we", ow_gp_we, m_gp_we);
      if (m_gp_we) begin
        check("gp_idx", ow_gp_idx, m_gp_idx);
        check("gp_data", ow_gp_data, m_gp_data);
      end
      check("sr_we", ow_sr_we, m_sr_we);
      if (m_sr_we) begin
        check("sr_idx", ow_sr_idx, m_sr_idx);
        check("sr_data", ow_sr_data, m_sr_data);
      end
      check("ar_we", ow_ar_we, m_ar_we);
      if (m_ar_we) begin
        check("ar_idx", ow_ar_idx, m_ar_idx);
        check("ar_data", ow_ar_data, m_ar_data);
      end
      check("stall", ow_stall, (m_pend && !iw_flush) || (!m_pend && iw_valid && !iw_flush && iw_srld));
      check("pc", ow_pc, m_pc);
      check("opc", ow_opc, m_opc);
      check("retire_cnt", ow_retire_cnt, 64'(m_retired % (1 << CW)));
    end
  end

  task automatic clear_inputs();
    iw_valid = 0; iw_flush = 0; iw_ld = 0; iw_srld = 0; iw_mem_mp = 0;
    iw_tgt_gp_we = 0; iw_tgt_sr_we = 0; iw_tgt_ar_we = 0;
    iw_tgt_gp = 0; iw_tgt_sr = 0; iw_tgt_ar = 0;
    iw_pc = 0; iw_opc = 0; iw_ar_result = 0;
    iw_mem_data0 = 0; iw_mem_data1 = 0; iw_result = 0;
  endtask

  task automatic step();
    @(posedge iw_clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    #1 iw_rst = 1;
    #2;
    check("rst gp_we", ow_gp_we, 0);
    check("rst sr_data", ow_sr_data, 0);
    check("rst cnt", ow_retire_cnt, 0);
    check("rst stall", ow_stall, 0);
    repeat (2) @(posedge iw_clk);
    #1 iw_rst = 0;

    // GP load through both memory ports
    iw_valid = 1; iw_ld = 1; iw_mem_mp = 1; iw_mem_data0 = 24'h123456; iw_mem_data1 = 24'hABCDEF;
    iw_tgt_gp = 5; iw_tgt_gp_we = 1; iw_pc = 48'h1000; iw_opc = 8'h11;
    step();
    check("ld0 we", ow_gp_we, 1);
    check("ld0 idx", ow_gp_idx, 5);
    check("ld0 data", ow_gp_data, 24'h123456);
    check("ld0 pc", ow_pc, 48'h1000);
    check("ld0 cnt", ow_retire_cnt, 1);
    iw_mem_mp = 0;
    step();
    check("ld1 data", ow_gp_data, 24'hABCDEF);
    check("ld1 cnt", ow_retire_cnt, 2);

    // Flushed ALU write
    iw_ld = 0; iw_result = 24'h000042; iw_flush = 1;
    step();
    check("flush we", ow_gp_we, 0);
    check("flush cnt", ow_retire_cnt, 2);

    // Two-beat SR load
    clear_inputs();
    iw_valid = 1; iw_srld = 1; iw_tgt_sr = 2; iw_mem_mp = 1; iw_mem_data0 = 24'h111111;
    #1 check("srld stall0", ow_stall, 1);
    step();
    check("srld we0", ow_sr_we, 0);
    iw_mem_mp = 0; iw_mem_data1 = 24'h222222;
    #1 check("srld stall1", ow_stall, 1);
    step();
    clear_inputs();
    check("srld we1", ow_sr_we, 1);
    check("srld idx", ow_sr_idx, 2);
    check("srld data", ow_sr_data, 48'h222222111111);
    check("srld cnt", ow_retire_cnt, 3);
    #1 check("srld stall2", ow_stall, 0);

    // SR load aborted by flush in its second beat
    iw_valid = 1; iw_srld = 1; iw_tgt_sr = 1; iw_mem_mp = 1; iw_mem_data0 = 24'h333333;
    step();
    iw_flush = 1;
    #1 check("abort stall", ow_stall, 0);
    step();
    check("abort we", ow_sr_we, 0);
    check("abort cnt", ow_retire_cnt, 3);
    clear_inputs();
    iw_valid = 1; iw_tgt_gp_we = 1; iw_tgt_gp = 3; iw_result = 24'h000077;
    step();
    check("post-abort we", ow_gp_we, 1);
    check("post-abort data", ow_gp_data, 24'h000077);
    check("post-abort cnt", ow_retire_cnt, 4);

    // Asynchronous reset in the middle of an SR load, then counter wrap
    clear_inputs();
    iw_valid = 1; iw_srld = 1; iw_tgt_sr = 3; iw_mem_mp = 1; iw_mem_data0 = 24'hAAAAAA; iw_pc = 48'h5;
    step();
    #2 iw_rst = 1;
    #1;
    clear_inputs();
    #1;
    check("arst cnt", ow_retire_cnt, 0);
    check("arst pc", ow_pc, 0);
    check("arst sr_we", ow_sr_we, 0);
    check("arst stall", ow_stall, 0);
    @(posedge iw_clk);
    #1 iw_rst = 0;
    iw_valid = 1; iw_srld = 1; iw_tgt_sr = 3; iw_mem_mp = 1; iw_mem_data0 = 24'hAAAAAA;
    #1 check("restart stall", ow_stall, 1);
    step();
    check("restart we0", ow_sr_we, 0);
    iw_mem_mp = 0; iw_mem_data1 = 24'hBBBBBB;
    step();
    clear_inputs();
    check("restart we1", ow_sr_we, 1);
    check("restart data", ow_sr_data, 48'hBBBBBBAAAAAA);
    check("restart cnt", ow_retire_cnt, 1);
    iw_valid = 1;
    repeat (16) step();
    check("wrap cnt", ow_retire_cnt, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      iw_valid     = ($urandom_range(3) != 0);
      iw_flush     = ($urandom_range(9) == 0);
      iw_srld      = ($urandom_range(6) == 0);
      iw_ld        = $urandom_range(1);
      iw_mem_mp    = $urandom_range(1);
      iw_tgt_gp_we = $urandom_range(1);
      iw_tgt_sr_we = $urandom_range(1);
      iw_tgt_ar_we = $urandom_range(1);
      iw_tgt_gp    = 4'($urandom);
      iw_tgt_sr    = 2'($urandom);
      iw_tgt_ar    = 2'($urandom);
      iw_pc        = {16'($urandom), 32'($urandom)};
      iw_opc       = 8'($urandom);
      iw_ar_result = {16'($urandom), 32'($urandom)};
      iw_mem_data0 = 24'($urandom);
      iw_mem_data1 = 24'($urandom);
      iw_result    = 24'($urandom);
      step();
    end

    clear_inputs();
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
